// File: rtl/md_scheduler.sv
// md_scheduler -- multiply/divide sequencer and HI/LO owner for the E stage.
//
// An md op sampled while idle has its 64-bit result computed straight away and
// parked in pending registers. The block then stays busy for MULT_CYCLES or
// DIV_CYCLES cycles and commits to HI/LO on the edge that ends the last busy
// cycle. This models the latency of an iterative unit, while keeping the
// arithmetic single-cycle.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high
//   md_op     in   [2:0]  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   a, b      in   [31:0] forwarded rs / rt operands
//   d_md_use  in   D-stage instruction touches HI/LO or the md unit
//   start     out  comb: md_op is 1..4 and the unit is not busy
//   busy      out  reg: an operation is in flight
//   hi, lo    out  [31:0] registered HI/LO
//   stall_md  out  comb: d_md_use && (start || busy)
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_md
);

  localparam int NMAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(NMAX + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_commit;  // cleared for divide-by-zero: HI/LO stay put
  logic [31:0]     r_hi, r_lo, r_phi, r_plo;

  logic            w_is_div, w_bzero;
  logic [63:0]     w_as, w_bs, w_au, w_bu, w_prod_s, w_prod_u;
  logic [31:0]     w_amag, w_bmag, w_bdiv_u, w_bdiv_s;
  logic [31:0]     w_qu, w_ru, w_qm, w_rm, w_qs, w_rs;
  logic [31:0]     w_nhi, w_nlo;

  assign start    = (md_op >= 3'd1) && (md_op <= 3'd4) && !r_busy;
  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  // Only inputs and the busy register feed the stall, never HI/LO.
  assign stall_md = d_md_use && (start || r_busy);

  assign w_is_div = (md_op == 3'd3) || (md_op == 3'd4);
  assign w_bzero  = (b == 32'd0);

  // Low 64 bits of the product of sign-extended operands is the signed product.
  assign w_as     = {{32{a[31]}}, a};
  assign w_bs     = {{32{b[31]}}, b};
  assign w_au     = {32'd0, a};
  assign w_bu     = {32'd0, b};
  assign w_prod_s = w_as * w_bs;
  assign w_prod_u = w_au * w_bu;

  // Signed divide on magnitudes, then fix signs: quotient truncates toward
  // zero, remainder follows the dividend. Avoids the INT_MIN/-1 trap of a
  // native signed divide. A zero divisor is replaced by 1 only to keep the
  // datapath defined; that result is never committed.
  assign w_bdiv_u = w_bzero ? 32'd1 : b;
  assign w_amag   = a[31] ? (~a + 32'd1) : a;
  assign w_bmag   = b[31] ? (~b + 32'd1) : b;
  assign w_bdiv_s = w_bzero ? 32'd1 : w_bmag;
  assign w_qu     = a / w_bdiv_u;
  assign w_ru     = a % w_bdiv_u;
  assign w_qm     = w_amag / w_bdiv_s;
  assign w_rm     = w_amag % w_bdiv_s;
  assign w_qs     = (a[31] ^ b[31]) ? (~w_qm + 32'd1) : w_qm;
  assign w_rs     = a[31] ? (~w_rm + 32'd1) : w_rm;

  always_comb begin
    w_nhi = 32'd0;
    w_nlo = 32'd0;
    case (md_op)
      3'd1: begin w_nhi = w_prod_s[63:32]; w_nlo = w_prod_s[31:0]; end
      3'd2: begin w_nhi = w_prod_u[63:32]; w_nlo = w_prod_u[31:0]; end
      3'd3: begin w_nhi = w_rs;            w_nlo = w_qs;           end
      3'd4: begin w_nhi = w_ru;            w_nlo = w_qu;           end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_commit <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_phi    <= 32'd0;
      r_plo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_phi    <= w_nhi;
            r_plo    <= w_nlo;
            r_commit <= !(w_is_div && w_bzero);
            r_cnt    <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else if (md_op == 3'd5) begin
            r_hi <= a;
          end else if (md_op == 3'd6) begin
            r_lo <= a;
          end
        end
        S_RUN: begin
          // md_op is ignored here: stall_md keeps new md ops out while busy.
          if (r_cnt == CW'(1)) begin
            if (r_commit) begin
              r_hi <= r_phi;
              r_lo <= r_plo;
            end
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Multiply/divide scheduler for the five-stage MIPS pipeline. Owns the HI/LO registers and sequences multi-cycle mult/multu/div/divu operations issued from the E stage. Generates `stall_md`, which freezes the PC and the F/D pipeline registers while a decode-stage HI/LO consumer would otherwise race an in-flight operation. Sits beside the E-stage ALU; its `hi`/`lo` outputs feed the E-stage result mux for mfhi/mflo.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `md_op`  in  3  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `a`  in  32  E-stage rs operand, forwarded.
- `b`  in  32  E-stage rt operand, forwarded.
- `d_md_use`  in  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- `start`  out  1  combinational: `md_op` in 1..4 and not `busy`.
- `busy`  out  1  registered: operation in flight.
- `hi`  out  32  registered HI.
- `lo`  out  32  registered LO.
- `stall_md`  out  1  combinational: `d_md_use && (start || busy)`; drives the PC's `stall_md`.

## Operation
- State: IDLE, RUN. Internals: cycle counter (width fits `DIV_CYCLES`), pending HI/LO result registers.
- IDLE, `start`: compute the result from `a`/`b`, latch it into the pending registers, load the counter with `MULT_CYCLES` or `DIV_CYCLES`, go to RUN, and set `busy`.
- RUN: decrement the counter each cycle. On the edge where the counter reaches 1, commit pending to HI/LO, clear `busy`, and return to IDLE.
- MULT: {hi,lo} = signed 32x32 -> 64 product. MULTU: unsigned product.
- DIV: lo = signed quotient truncated toward zero, hi = remainder with the sign of the dividend. DIVU: unsigned quotient/remainder.
- Divide by zero (`b==0`, DIV/DIVU): runs the full `DIV_CYCLES` busy period, and HI/LO keep their prior values.
- MTHI/MTLO in IDLE: `hi`/`lo` <= `a` at the next edge. `busy` is not asserted.
- Any `md_op` 1..6 arriving while `busy` is ignored. This is a protocol violation, because `stall_md` prevents it. HI/LO and the counter are unaffected.
- Reset at any time, including mid-RUN: state IDLE, counter 0, `busy`=0, `hi`=`lo`=0, pending cleared, and the in-flight result is discarded.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0. `start`/`stall_md` follow their inputs combinationally.
- Op sampled at edge T0 (`start`=1 in cycle T0-1→T0). `busy`=1 for exactly N cycles following T0, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- HI/LO update on the edge that ends the N-th busy cycle. An mfhi/mflo in E in the next cycle reads the new value with zero extra delay.
- Back-to-back: a new md op may start in the first cycle `busy`=0.
- `stall_md` is asserted in the `start` cycle plus all N busy cycles whenever `d_md_use`=1, giving at most N+1 stall cycles.
- No combinational path from `hi`/`lo` to `stall_md`.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 -> `busy` high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIVU a=7, b=2 -> `busy` high 10 cycles, then lo=3, hi=1. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MULT with `d_md_use`=1 held throughout -> `stall_md`=1 for exactly 6 consecutive cycles, dropping in the cycle `busy` falls. With `d_md_use`=0 -> `stall_md` stays 0.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next edge, `busy` stays 0. DIVU b=0 after it -> 10 busy cycles, hi=0x12345678, lo unchanged.
- DIV issued, then a second MULT presented during cycle 3 of busy -> ignored; final result is the DIV result, `busy` falls after 10 cycles.
- MULT started, `reset` pulsed on busy cycle 2 -> next edge `busy`=0, hi=lo=0, and no commit occurs later.
